// File: rtl/core_pkg.sv
// core_pkg
//   Shared definitions for the 5-stage RV64 core: supported major opcodes and
//   the bit positions of the 8-bit decoder control word
//   {ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}.
//   Used by the decoder, ID/EX and EX/MEM stages.
package core_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam int CTRL_W        = 8;
  localparam int CTRL_ALUOP_LO = 0;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_ALUSRC   = 7;

  // Opcodes this pipeline executes; anything else becomes a bubble.
  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LD) || (op == OP_SD) || (op == OP_BEQ);
  endfunction

  // R, S and SB formats read rs2; loads do not.
  function automatic logic op_uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_SD) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect
//   Combinational load-use detector. Requests a one-cycle stall when the load
//   currently in EX writes a register that the ID instruction reads.
// Ports
//   id_valid, flush        ID qualifier and branch squash (squash wins)
//   id_opcode, id_rs1/2    ID instruction source specifiers
//   ex_valid, ex_mem_read  EX instruction is a real load
//   ex_rd                  EX destination
//   stall                  load-use stall request
module hazard_detect
  import core_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            id_valid,
  input  logic            flush,
  input  logic [6:0]      id_opcode,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rd,
  output logic            stall
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = (ex_rd == id_rs1);
    rs2_hit = op_uses_rs2(id_opcode) && (ex_rd == id_rs2);
    // A squashed ID instruction never needs to be held.
    stall   = id_valid && !flush && ex_valid && ex_mem_read &&
              (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register of the RV64 core. Sanitises decoder control bits,
//   detects load-use hazards against EX, and registers either the ID
//   instruction or a bubble. Keeps saturating stall/bubble counters.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   id_valid, id_opcode        ID qualifier and major opcode
//   id_ctrl                    decoder control word
//   id_pc, id_rs1_data, id_rs2_data, id_imm   ID operands (XLEN)
//   id_rs1, id_rs2, id_rd      register specifiers
//   id_funct                   {instr[30], instr[14:12]}
//   flush                      squash ID (branch taken downstream)
//   stall                      load-use hold request to PC and IF/ID
//   ex_*                       registered EX-side copies
//   stall_cnt, bubble_cnt      saturating event counters
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [3:0]        id_funct,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [RA_W-1:0]   ex_rd,
  output logic [3:0]        ex_funct,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              op_ok;
  logic              bubble;
  logic [CTRL_W-1:0] ctrl_san;

  hazard_detect #(.RA_W(RA_W)) u_hazard_detect (
    .id_valid    (id_valid),
    .flush       (flush),
    .id_opcode   (id_opcode),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEMREAD]),
    .ex_rd       (ex_rd),
    .stall       (stall)
  );

  always_comb begin
    op_ok    = op_supported(id_opcode);
    ctrl_san = id_ctrl;
    // Stores and branches never write back; force the operand mux to the
    // form each format actually uses (imm for address, rs2 for compare).
    if (id_opcode == OP_SD) begin
      ctrl_san[CTRL_MEMTOREG] = 1'b0;
      ctrl_san[CTRL_ALUSRC]   = 1'b1;
    end else if (id_opcode == OP_BEQ) begin
      ctrl_san[CTRL_MEMTOREG] = 1'b0;
      ctrl_san[CTRL_ALUSRC]   = 1'b0;
    end
    bubble = flush || stall || !id_valid || !op_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct    <= '0;
      stall_cnt   <= '0;
      bubble_cnt  <= '0;
    end else begin
      // Operands always follow ID; a bubble is identified by ex_valid and a
      // zeroed control word, so stale operands are harmless downstream.
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct    <= id_funct;
      ex_valid    <= !bubble;
      ex_ctrl     <= bubble ? '0 : ctrl_san;
      if (stall && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (bubble && !(&bubble_cnt))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import core_pkg::*;

  localparam int XLEN  = 64;
  localparam int RA_W  = 5;
  localparam int CNT_W = 32;
  localparam int SAT_W = 2;
  localparam longint MAX_BIG = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX_SAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            id_valid;
  logic [6:0]      id_opcode;
  logic [7:0]      id_ctrl;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic [3:0]      id_funct;
  logic            flush;

  logic            stall, ex_valid;
  logic [7:0]      ex_ctrl;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0]      ex_funct;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;

  logic            s_stall, s_ex_valid;
  logic [7:0]      s_ex_ctrl;
  logic [XLEN-1:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
  logic [RA_W-1:0] s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [3:0]      s_ex_funct;
  logic [SAT_W-1:0] s_stall_cnt, s_bubble_cnt;

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_ctrl(id_ctrl), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance so saturation is reached in a few events.
  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(SAT_W)) u_dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_ctrl(id_ctrl), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct), .flush(flush),
    .stall(s_stall), .ex_valid(s_ex_valid), .ex_ctrl(s_ex_ctrl), .ex_pc(s_ex_pc),
    .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm),
    .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_funct(s_ex_funct),
    .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: what EX holds, described at instruction level.
  bit              m_known = 0;
  bit              m_valid;
  logic [7:0]      m_ctrl;
  logic [XLEN-1:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [RA_W-1:0] m_rs1, m_rs2, m_rd;
  logic [3:0]      m_funct;
  longint          m_scnt, m_bcnt, m_scnt_s, m_bcnt_s;

  function automatic bit is_known_op(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011;
  endfunction

  function automatic bit model_stall();
    bit reads_rs2;
    bit is_load_in_ex;
    reads_rs2     = (id_opcode == 7'b0110011) || (id_opcode == 7'b0100011) ||
                    (id_opcode == 7'b1100011);
    is_load_in_ex = m_valid && m_ctrl[4];
    if (!id_valid || flush || !is_load_in_ex || m_rd == 0) return 0;
    return (m_rd == id_rs1) || (reads_rs2 && m_rd == id_rs2);
  endfunction

  function automatic logic [7:0] model_ctrl(input logic [6:0] op, input logic [7:0] c);
    logic [7:0] r;
    r = c;
    if (op == 7'b0100011) r = (r & 8'h3F) | 8'h80;   // store: no MemToReg, ALUSrc=imm
    if (op == 7'b1100011) r = r & 8'h3F;             // branch: no MemToReg, ALUSrc=rs2
    return r;
  endfunction

  task automatic check_outputs();
    check_eq("ex_valid", 64'(ex_valid), 64'(m_valid));
    check_eq("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
    check_eq("ex_pc", ex_pc, m_pc);
    check_eq("ex_rs1_data", ex_rs1_data, m_rs1d);
    check_eq("ex_rs2_data", ex_rs2_data, m_rs2d);
    check_eq("ex_imm", ex_imm, m_imm);
    check_eq("ex_regs", 64'({ex_rs1, ex_rs2, ex_rd, ex_funct}),
             64'({m_rs1, m_rs2, m_rd, m_funct}));
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
    check_eq("bubble_cnt", 64'(bubble_cnt), 64'(m_bcnt));
    check_eq("sat_ex", 64'({s_ex_valid, s_ex_ctrl, s_ex_rs1, s_ex_rs2, s_ex_rd, s_ex_funct}),
             64'({m_valid, m_ctrl, m_rs1, m_rs2, m_rd, m_funct}));
    check_eq("sat_ops", s_ex_pc ^ s_ex_rs1_data ^ s_ex_rs2_data ^ s_ex_imm,
             m_pc ^ m_rs1d ^ m_rs2d ^ m_imm);
    check_eq("sat_stall_cnt", 64'(s_stall_cnt), 64'(m_scnt_s));
    check_eq("sat_bubble_cnt", 64'(s_bubble_cnt), 64'(m_bcnt_s));
  endtask

  // One clock: inputs were driven just after the previous rising edge.
  task automatic tick();
    bit s, bub;
    #1;
    s = m_known ? model_stall() : 1'b0;
    if (m_known) begin
      check_eq("stall", 64'(stall), 64'(s));
      check_eq("sat_stall", 64'(s_stall), 64'(s));
    end
    @(posedge clk);
    if (reset) begin
      m_known = 1;
      m_valid = 0; m_ctrl = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_funct = 0;
      m_scnt = 0; m_bcnt = 0; m_scnt_s = 0; m_bcnt_s = 0;
    end else if (m_known) begin
      bub = flush || s || !id_valid || !is_known_op(id_opcode);
      if (s && m_scnt < MAX_BIG) m_scnt++;
      if (s && m_scnt_s < MAX_SAT) m_scnt_s++;
      if (bub && m_bcnt < MAX_BIG) m_bcnt++;
      if (bub && m_bcnt_s < MAX_SAT) m_bcnt_s++;
      m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_funct = id_funct;
      m_valid = !bub;
      m_ctrl  = bub ? 8'h00 : model_ctrl(id_opcode, id_ctrl);
    end
    #1;
    if (m_known) check_outputs();
  endtask

  task automatic drive_data();
    id_pc       = {$urandom, $urandom};
    id_rs1_data = {$urandom, $urandom};
    id_rs2_data = {$urandom, $urandom};
    id_imm      = {$urandom, $urandom};
    id_funct    = 4'($urandom);
  endtask

  task automatic drive_instr(input logic [6:0] op, input logic [7:0] c,
                             input int rd, input int rs1, input int rs2, input bit fl);
    id_valid = 1; id_opcode = op; id_ctrl = c; flush = fl;
    id_rd = RA_W'(rd); id_rs1 = RA_W'(rs1); id_rs2 = RA_W'(rs2);
    drive_data();
  endtask

  task automatic drive_rand();
    logic [6:0] ops [5];
    ops[0] = OP_R; ops[1] = OP_LD; ops[2] = OP_SD; ops[3] = OP_BEQ; ops[4] = 7'h13;
    id_valid  = ($urandom_range(0, 7) != 0);
    id_opcode = ops[$urandom_range(0, 4)];
    id_ctrl   = 8'($urandom);
    id_rd     = RA_W'($urandom_range(0, 3));
    id_rs1    = RA_W'($urandom_range(0, 3));
    id_rs2    = RA_W'($urandom_range(0, 3));
    flush     = ($urandom_range(0, 7) == 0);
    drive_data();
  endtask

  task automatic do_reset();
    reset = 1;
    drive_rand();
    tick();
    drive_rand();
    tick();
    reset = 0;
  endtask

  initial begin
    bit held;
    reset = 1;
    drive_rand();
    @(posedge clk); #1;

    // Reset with random inputs.
    do_reset();
    check_eq("rst_ex_valid", 64'(ex_valid), 64'd0);
    check_eq("rst_ex_ctrl", 64'(ex_ctrl), 64'd0);
    check_eq("rst_ex_pc", ex_pc, 64'd0);
    check_eq("rst_ex_rd", 64'(ex_rd), 64'd0);
    check_eq("rst_cnts", 64'({stall_cnt, bubble_cnt}), 64'd0);

    // Pass-through: add x3,x1,x2.
    drive_instr(OP_R, 8'h22, 3, 1, 2, 0);
    #1 check_eq("rst_stall", 64'(stall), 64'd0);
    tick();
    check_eq("pt_ctrl", 64'(ex_ctrl), 64'h22);
    check_eq("pt_rd", 64'(ex_rd), 64'd3);
    check_eq("pt_valid", 64'(ex_valid), 64'd1);

    // Load-use: ld x5 ; add x6,x5,x7.
    do_reset();
    drive_instr(OP_LD, 8'hF0, 5, 1, 0, 0);
    tick();
    drive_instr(OP_R, 8'h22, 6, 5, 7, 0);
    #1 check_eq("lu_stall1", 64'(stall), 64'd1);
    tick();
    check_eq("lu_bubble", 64'(ex_valid), 64'd0);
    check_eq("lu_stall_clr", 64'(stall), 64'd0);
    tick();
    check_eq("lu_add_valid", 64'(ex_valid), 64'd1);
    check_eq("lu_add_rd", 64'(ex_rd), 64'd6);
    check_eq("lu_stall_cnt", 64'(stall_cnt), 64'd1);
    check_eq("lu_bubble_cnt", 64'(bubble_cnt), 64'd1);

    // Load to x0 never stalls.
    drive_instr(OP_LD, 8'hF0, 0, 1, 0, 0);
    tick();
    drive_instr(OP_R, 8'h22, 6, 0, 0, 0);
    #1 check_eq("x0_stall", 64'(stall), 64'd0);
    tick();
    check_eq("x0_valid", 64'(ex_valid), 64'd1);

    // Flush beats hazard; squashed add never reaches EX.
    drive_instr(OP_LD, 8'hF0, 5, 1, 0, 0);
    tick();
    drive_instr(OP_R, 8'h22, 6, 5, 7, 1);
    #1 check_eq("fl_stall", 64'(stall), 64'd0);
    tick();
    check_eq("fl_bubble", 64'(ex_valid), 64'd0);
    check_eq("fl_ctrl", 64'(ex_ctrl), 64'd0);

    // Sanitising.
    drive_instr(OP_SD, 8'hC8, 0, 2, 3, 0);
    tick();
    check_eq("san_sd", 64'(ex_ctrl), 64'h88);
    drive_instr(OP_BEQ, 8'hC5, 0, 2, 3, 0);
    tick();
    check_eq("san_beq", 64'(ex_ctrl), 64'h05);
    drive_instr(7'h13, 8'h22, 4, 2, 3, 0);
    tick();
    check_eq("san_bad_valid", 64'(ex_valid), 64'd0);
    check_eq("san_bad_ctrl", 64'(ex_ctrl), 64'd0);

    // Randomised traffic; IF/ID holds while stalled, occasional reset.
    held = 0;
    for (int i = 0; i < 400; i++) begin
      if (!held) drive_rand();
      reset = ($urandom_range(0, 49) == 0);
      #1 held = stall;
      tick();
    end
    reset = 0;

    // Saturation of the narrow counters: four load-use stalls.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_instr(OP_LD, 8'hF0, 5, 1, 0, 0);
      tick();
      drive_instr(OP_SD, 8'hC8, 0, 2, 5, 0);
      tick();
      tick();
    end
    check_eq("sat_scnt", 64'(s_stall_cnt), 64'd3);
    check_eq("sat_bcnt", 64'(s_bubble_cnt), 64'd3);
    check_eq("big_scnt", 64'(stall_cnt), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
